// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one down-counting delay timer among N_REQ requesters.
// The granted requester's delay is loaded, counted to zero, then a one-cycle done pulse is returned.
module delay_timer_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] delay,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [W-1:0]       cnt
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StCount, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   cand;
  logic              found;

  // First active request scanning upward from the last grant, wrapping around.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          ptr_d       = pick;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (!req[ptr_q]) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d   = delay[32'(ptr_q) * W +: W];
          state_d = StCount;
        end
      end
      StCount: begin
        // The countdown step still lands on an abort edge; only the FSM bails out.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - W'(1);
        end
        if (!req[ptr_q]) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          done_d  = gnt_q;
          state_d = StDone;
        end
      end
      StDone: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '1;
      ptr_q   <= IdxW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Self-checking bench for delay_timer_arbiter: vector table, corner-case sequences and
// randomized traffic against a job-timeline reference model.
module tb_delay_timer_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] delay = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt;

  delay_timer_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .delay (delay),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] d;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] cnt;
  } vec_t;

  vec_t vecs[15];

  // Reference model: a job is described by its owner and the number of edges since grant.
  int m_owner, m_k, m_dly, m_cnt, m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_owner = -1;
    m_k     = 0;
    m_dly   = 0;
    m_cnt   = (1 << W) - 1;
    m_ptr   = N - 1;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] dl);
    bit hit;
    int c;
    if (m_owner < 0) begin
      hit = 1'b0;
      for (int o = 1; o <= N; o++) begin
        c = (m_ptr + o) % N;
        if (!hit && r[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_ptr   = c;
          m_k     = 0;
        end
      end
    end else if (m_k >= 1 && m_k == m_dly + 2) begin
      m_owner = -1;
    end else if (!r[m_owner]) begin
      if (m_k >= 1) m_cnt = (m_dly - m_k > 0) ? m_dly - m_k : 0;
      m_owner = -1;
    end else begin
      m_k++;
      if (m_k == 1) m_dly = int'(dl[m_owner*W +: W]);
      m_cnt = (m_dly - (m_k - 1) > 0) ? m_dly - (m_k - 1) : 0;
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [N-1:0] g, dn;
    g  = '0;
    dn = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      if (m_k >= 1 && m_k == m_dly + 2) dn[m_owner] = 1'b1;
    end
    return {g, dn, (m_owner >= 0), W'(m_cnt)};
  endfunction

  function automatic int first_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int ev_cyc[8];
  int ev_idx[8];
  int n_ev;
  logic [W-1:0] dv;

  initial begin
    // Single request D=5 on requester 2, then D=0 on requester 1.
    vecs[0]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd7};
    vecs[1]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd5};
    vecs[2]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd4};
    vecs[3]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd3};
    vecs[4]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd2};
    vecs[5]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd1};
    vecs[6]  = '{4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b1, 3'd0};
    vecs[7]  = '{4'b0100, 3'd5, 4'b0100, 4'b0100, 1'b1, 3'd0};
    vecs[8]  = '{4'b0000, 3'd5, 4'b0000, 4'b0000, 1'b0, 3'd0};
    vecs[9]  = '{4'b0000, 3'd5, 4'b0000, 4'b0000, 1'b0, 3'd0};
    vecs[10] = '{4'b0010, 3'd0, 4'b0010, 4'b0000, 1'b1, 3'd0};
    vecs[11] = '{4'b0010, 3'd0, 4'b0010, 4'b0000, 1'b1, 3'd0};
    vecs[12] = '{4'b0010, 3'd0, 4'b0010, 4'b0010, 1'b1, 3'd0};
    vecs[13] = '{4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0};
    vecs[14] = '{4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b0, 3'd0};

    // Reset is asynchronous: visible before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd7);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req   = vecs[i].req;
      dv    = vecs[i].d;
      delay = {N{dv}};
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
    end

    // Reset asserted mid-COUNT clears everything immediately.
    do_reset();
    req   = 4'b0100;
    dv    = 3'd5;
    delay = {N{dv}};
    repeat (3) tick();
    chk("midcount_cnt_before", 32'(cnt), 32'd4);
    rst = 1'b0;
    #1;
    chk("midreset_out", {gnt, done, busy, cnt}, {4'b0000, 4'b0000, 1'b0, 3'd7});
    req = 4'b1111;
    #1 rst = 1'b1;
    tick();
    chk("post_reset_first_gnt", 32'(gnt), 32'b0001);

    // Round-robin with all requesters held high, D=1.
    do_reset();
    req   = 4'b1111;
    dv    = 3'd1;
    delay = {N{dv}};
    n_ev  = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done != '0 && n_ev < 8) begin
        ev_cyc[n_ev] = c;
        ev_idx[n_ev] = first_bit(done);
        n_ev++;
      end
    end
    chk("rr_event_count", 32'(n_ev >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < n_ev) begin
        chk($sformatf("rr_order%0d", i), 32'(ev_idx[i]), 32'(i % N));
        if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(ev_cyc[i] - ev_cyc[i-1]), 32'd5);
      end
    end

    // Abort: requester 3 drops its request while cnt shows 4.
    do_reset();
    req   = 4'b1000;
    dv    = 3'd6;
    delay = {N{dv}};
    tick();
    chk("abort_gnt", 32'(gnt), 32'b1000);
    repeat (3) tick();
    chk("abort_cnt_before", 32'(cnt), 32'd4);
    req = 4'b0000;
    tick();
    chk("abort_out", {gnt, done, busy, cnt}, {4'b0000, 4'b0000, 1'b0, 3'd3});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_idle%0d", i), {gnt, done, busy, cnt}, {4'b0000, 4'b0000, 1'b0, 3'd3});
    end
    req = 4'b1111;
    tick();
    chk("abort_next_gnt", 32'(gnt), 32'b0001);

    // Collision: req[0] rises in the cycle done[2] is high.
    do_reset();
    req   = 4'b0100;
    dv    = 3'd1;
    delay = {N{dv}};
    tick();
    chk("coll_gnt", 32'(gnt), 32'b0100);
    repeat (3) tick();
    chk("coll_done", 32'(done), 32'b0100);
    req = 4'b0001;
    tick();
    chk("coll_idle", {gnt, busy}, {4'b0000, 1'b0});
    tick();
    chk("coll_gnt0", {gnt, busy}, {4'b0001, 1'b1});

    // Randomized traffic against the reference model.
    do_reset();
    req   = '0;
    delay = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      delay = N*W'($urandom);
      model_edge(req, delay);
      tick();
      chk($sformatf("random_c%0d", c), 32'({gnt, done, busy, cnt}), 32'(model_out()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shares one 3-bit down-counting delay timer among several requesters. Each requester asks for a delay of 0-7 cycles; the block grants the timer round-robin, loads and runs it, and returns a one-cycle completion pulse to the owner. It sits between the control FSMs that need short programmable waits and the shared countdown resource, so the design needs only one timer instead of one per client.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 3, timer/delay width in bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request; held high until its done pulse, or dropped to abort
- delay  in  N_REQ*W  packed delay values; slice i = delay[i*W +: W]; sampled only in LOAD
- gnt  out  N_REQ  one-hot (or zero) registered grant
- done  out  N_REQ  one-hot single-cycle completion pulse to the owner
- busy  out  1  high whenever state is not IDLE
- cnt  out  W  current timer value (observation/debug)

## Operation
- Reset (rst=0, immediate, no clock needed): state=IDLE, gnt=0, done=0, busy=0, cnt=all ones (3'b111), last-grant pointer=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE: if any req is high, pick the first high req scanning upward from pointer+1, wrapping modulo N_REQ. Set gnt to that bit, update the pointer to it, and go to LOAD. Otherwise stay; cnt holds its value.
- LOAD: cnt <= delay slice of the granted index. Go to COUNT.
- COUNT: if cnt==0, go to DONE. Otherwise cnt <= cnt-1, modulo 2^W, and stay. Underflow never occurs because the zero check comes first.
- DONE: done[g]=1 for exactly this cycle, and gnt stays high. At the next edge, gnt=0, done=0, and state goes to IDLE.
- Abort: if req[g] is low in LOAD or COUNT, the next edge goes to IDLE with gnt=0 and no done pulse. cnt freezes at its current value, and the pointer keeps the aborted index. Dropping req[g] during DONE is ignored; the done pulse still fires.
- Requests from non-granted requesters are ignored until IDLE. There is no queuing beyond the held req level.
- Simultaneous events: a new req arriving in the same cycle as DONE is only arbitrated in the following IDLE cycle. There is at least one IDLE cycle between consecutive grants.
- The delay input of the non-granted requesters, and of the granted one outside LOAD, is don't-care.

## Timing
- Let edge E be the edge that samples req in IDLE; gnt rises after E.
- cnt=D after edge E+1.
- cnt reaches 0 after edge E+1+D.
- done is high for the cycle after edge E+2+D.
- gnt and done both fall after edge E+3+D, and the next grant can appear after edge E+4+D.
- D=0: done is high after edge E+2. The minimum grant-to-done time is 2 cycles.
- Arbitration throughput: one job per D+4 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation clears everything immediately. After rst rises, the first grant comes on the first edge with req high.

## Test plan
- Reset behaviour: assert rst=0 mid-COUNT -> gnt, done and busy are 0 and cnt=3'b111 immediately; the first grant after release goes to req[0] when all req are high.
- Single request, D=5: req[2]=1 at edge E -> gnt=4'b0100 after E, cnt counts 5,4,3,2,1,0, done=4'b0100 for exactly one cycle after E+7, then gnt=0 after E+8.
- Zero delay: req[1] with D=0 -> done[1] is high after edge E+2; cnt shows 0; no wrap to 7.
- Round-robin fairness: all four req held high with D=1 -> grant order 0,1,2,3,0,... with each done separated by 5 cycles and no requester skipped.
- Abort: req[3] dropped while cnt=4 in COUNT -> next edge gives IDLE and gnt=0, no done[3] ever, and cnt frozen at 3. With all req high, the next grant goes to requester 0.
- Collision at DONE: req[0] rises in the same cycle as done[2] -> req[0] is granted one edge after the IDLE cycle, not before, and busy drops for exactly one cycle.
